// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM front-end blocks.
package atm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        CHECK    = 2'd2,
        VERIFIED = 2'd3
    } pin_state_t;

    localparam int MAX_PIN_ATTEMPTS = 3;
    localparam int BCD_W            = 4;
    localparam int ATT_W            = $clog2(MAX_PIN_ATTEMPTS + 1);

endpackage

// File: rtl/atm_pin_if.sv
// Card / keypad / admin signals between the ATM session logic and the PIN verifier.
import atm_pkg::*;

interface atm_pin_if #(
    parameter int PIN_DIGITS = 4,
    parameter int ACCT_W     = 2
) ();
    logic                          card_in;
    logic [ACCT_W-1:0]             card_id;
    logic                          digit_valid;
    logic [BCD_W-1:0]              digit;
    logic                          clear_key;
    logic                          enter_key;
    logic                          timeout;
    logic                          session_end;
    logic                          pin_wr_en;
    logic [ACCT_W-1:0]             pin_wr_acct;
    logic [BCD_W*PIN_DIGITS-1:0]   pin_wr_data;
    logic                          psw_en;
    logic                          wrong_psw;
    logic                          pin_ok;
    logic                          card_rejected;
    logic [2**ACCT_W-1:0]          locked;
    logic [$clog2(PIN_DIGITS+1)-1:0] digit_count;

    modport master (
        output card_in, card_id, digit_valid, digit, clear_key, enter_key,
               timeout, session_end, pin_wr_en, pin_wr_acct, pin_wr_data,
        input  psw_en, wrong_psw, pin_ok, card_rejected, locked, digit_count
    );

    modport slave (
        input  card_in, card_id, digit_valid, digit, clear_key, enter_key,
               timeout, session_end, pin_wr_en, pin_wr_acct, pin_wr_data,
        output psw_en, wrong_psw, pin_ok, card_rejected, locked, digit_count
    );
endinterface

// File: rtl/atm_pin_store.sv
// Per-account stored PIN, consecutive-failure counter and lock bit.
import atm_pkg::*;

module atm_pin_store #(
    parameter int PIN_DIGITS = 4,
    parameter int ACCT_W     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ACCT_W-1:0]           wr_acct,
    input  logic [BCD_W*PIN_DIGITS-1:0] wr_data,
    input  logic [ACCT_W-1:0]           rd_acct,
    output logic [BCD_W*PIN_DIGITS-1:0] rd_pin,
    output logic [ATT_W-1:0]            rd_attempts,
    input  logic                        fail_en,
    input  logic                        clr_en,
    output logic [2**ACCT_W-1:0]        locked
);
    localparam int PIN_W    = BCD_W * PIN_DIGITS;
    localparam int NUM_ACCT = 2 ** ACCT_W;

    logic [PIN_W-1:0] pin_all [NUM_ACCT];
    logic [ATT_W-1:0] att_all [NUM_ACCT];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACCT; gi++) begin : g_acct
            logic [PIN_W-1:0] pin_reg;
            logic [ATT_W-1:0] att_reg;
            logic             lock_reg;
            logic             wr_hit;
            logic             cmd_hit;

            assign wr_hit  = wr_en && (wr_acct == ACCT_W'(gi));
            assign cmd_hit = rd_acct == ACCT_W'(gi);

            // The admin write is checked first so it wins over a lock in the same cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pin_reg  <= '0;
                    att_reg  <= '0;
                    lock_reg <= 1'b0;
                end else if (wr_hit) begin
                    pin_reg  <= wr_data;
                    att_reg  <= '0;
                    lock_reg <= 1'b0;
                end else if (cmd_hit && clr_en) begin
                    att_reg <= '0;
                end else if (cmd_hit && fail_en) begin
                    if (att_reg == ATT_W'(MAX_PIN_ATTEMPTS - 1)) begin
                        att_reg  <= '0;
                        lock_reg <= 1'b1;
                    end else begin
                        att_reg <= att_reg + 1'b1;
                    end
                end
            end

            assign pin_all[gi] = pin_reg;
            assign att_all[gi] = att_reg;
            assign locked[gi]  = lock_reg;
        end
    endgenerate

    assign rd_pin      = pin_all[rd_acct];
    assign rd_attempts = att_all[rd_acct];

endmodule

// File: rtl/atm_pin_verifier.sv
// PIN entry FSM and digit buffer; authenticates a card against its stored PIN.
import atm_pkg::*;

module atm_pin_verifier #(
    parameter int PIN_DIGITS = 4,
    parameter int ACCT_W     = 2
) (
    input  logic     clk,
    input  logic     rst,
    atm_pin_if.slave bus
);
    localparam int PIN_W    = BCD_W * PIN_DIGITS;
    localparam int CNT_W    = $clog2(PIN_DIGITS + 1);
    localparam int NUM_ACCT = 2 ** ACCT_W;

    pin_state_t        state_reg, state_next;
    logic [PIN_W-1:0]  pin_buf_reg, pin_buf_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [ACCT_W-1:0] acct_reg, acct_next;
    logic              psw_en_reg, psw_en_next;
    logic              wrong_reg, wrong_next;
    logic              ok_reg, ok_next;
    logic              rejected_reg, rejected_next;

    logic [PIN_W-1:0]    stored_pin;
    logic [ATT_W-1:0]    stored_att;
    logic [NUM_ACCT-1:0] locked;
    logic                fail_en;
    logic                clr_en;
    logic                pin_match;

    atm_pin_store #(
        .PIN_DIGITS (PIN_DIGITS),
        .ACCT_W     (ACCT_W)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (bus.pin_wr_en),
        .wr_acct     (bus.pin_wr_acct),
        .wr_data     (bus.pin_wr_data),
        .rd_acct     (acct_reg),
        .rd_pin      (stored_pin),
        .rd_attempts (stored_att),
        .fail_en     (fail_en),
        .clr_en      (clr_en),
        .locked      (locked)
    );

    // A short buffer never matches, even if its low digits happen to agree.
    assign pin_match = (count_reg == CNT_W'(PIN_DIGITS)) && (pin_buf_reg == stored_pin);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            pin_buf_reg  <= '0;
            count_reg    <= '0;
            acct_reg     <= '0;
            psw_en_reg   <= 1'b0;
            wrong_reg    <= 1'b0;
            ok_reg       <= 1'b0;
            rejected_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pin_buf_reg  <= pin_buf_next;
            count_reg    <= count_next;
            acct_reg     <= acct_next;
            psw_en_reg   <= psw_en_next;
            wrong_reg    <= wrong_next;
            ok_reg       <= ok_next;
            rejected_reg <= rejected_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pin_buf_next  = pin_buf_reg;
        count_next    = count_reg;
        acct_next     = acct_reg;
        psw_en_next   = 1'b0;
        wrong_next    = 1'b0;
        ok_next       = 1'b0;
        rejected_next = 1'b0;
        fail_en       = 1'b0;
        clr_en        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.card_in) begin
                    acct_next    = bus.card_id;
                    pin_buf_next = '0;
                    count_next   = '0;
                    if (locked[bus.card_id]) begin
                        rejected_next = 1'b1;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (bus.timeout) begin
                    state_next   = IDLE;
                    pin_buf_next = '0;
                    count_next   = '0;
                end else if (bus.clear_key) begin
                    pin_buf_next = '0;
                    count_next   = '0;
                end else if (bus.enter_key) begin
                    state_next = CHECK;
                end else if (bus.digit_valid && (bus.digit <= 4'd9)
                             && (count_reg < CNT_W'(PIN_DIGITS))) begin
                    pin_buf_next = (pin_buf_reg << BCD_W) | PIN_W'(bus.digit);
                    count_next   = count_reg + 1'b1;
                end
            end
            CHECK: begin
                pin_buf_next = '0;
                count_next   = '0;
                if (pin_match) begin
                    ok_next     = 1'b1;
                    psw_en_next = 1'b1;
                    clr_en      = 1'b1;
                    state_next  = VERIFIED;
                end else begin
                    wrong_next = 1'b1;
                    fail_en    = 1'b1;
                    // This failure is the one that locks the account.
                    if (stored_att == ATT_W'(MAX_PIN_ATTEMPTS - 1)) begin
                        state_next = IDLE;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end
            VERIFIED: begin
                if (bus.session_end || bus.timeout) begin
                    state_next = IDLE;
                end else begin
                    psw_en_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.psw_en        = psw_en_reg;
    assign bus.wrong_psw     = wrong_reg;
    assign bus.pin_ok        = ok_reg;
    assign bus.card_rejected = rejected_reg;
    assign bus.locked        = locked;
    assign bus.digit_count   = count_reg;

endmodule

// File: tb/tb_atm_pin_verifier.sv
// Directed bench for atm_pin_verifier with a queue of expected compare results.
module tb_atm_pin_verifier;

    logic clk = 1'b0;
    logic rst = 1'b1;

    atm_pin_if #(.PIN_DIGITS(4), .ACCT_W(2)) bus ();

    atm_pin_verifier #(.PIN_DIGITS(4), .ACCT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] R_NONE  = 2'b00;
    localparam logic [1:0] R_OK    = 2'b01;
    localparam logic [1:0] R_WRONG = 2'b10;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    logic [1:0] exp_q [$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic key(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        cyc();
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic key_pin(input logic [15:0] p);
        for (int i = 3; i >= 0; i--) key(p[i*4 +: 4]);
    endtask

    task automatic card(input logic [1:0] id);
        bus.card_in = 1'b1;
        bus.card_id = id;
        cyc();
        bus.card_in = 1'b0;
        $display("txn card_in: id=%0d rejected=%0b", id, bus.card_rejected);
    endtask

    task automatic admin_write(input logic [1:0] acct, input logic [15:0] p);
        bus.pin_wr_en   = 1'b1;
        bus.pin_wr_acct = acct;
        bus.pin_wr_data = p;
        cyc();
        bus.pin_wr_en = 1'b0;
        $display("txn pin_write: acct=%0d pin=%04h", acct, p);
    endtask

    task automatic end_session();
        bus.session_end = 1'b1;
        cyc();
        bus.session_end = 1'b0;
        chk("psw_en_after_session_end", bus.psw_en, 0);
    endtask

    // Press enter, then wait (bounded) for the result pulse and score it.
    task automatic submit(input logic [1:0] expect_res);
        int         lat;
        logic [1:0] res;
        logic [1:0] want;
        exp_q.push_back(expect_res);
        bus.enter_key = 1'b1;
        cyc();
        bus.enter_key = 1'b0;
        chk("no_result_in_check", {bus.wrong_psw, bus.pin_ok}, R_NONE);
        lat = 1;
        res = R_NONE;
        for (int i = 0; i < 6; i++) begin
            cyc();
            lat++;
            res = {bus.wrong_psw, bus.pin_ok};
            if (res != R_NONE) break;
        end
        want = exp_q.pop_front();
        chk("result_latency", lat, 2);
        chk("result", res, want);
        chk("psw_en_with_result", bus.psw_en, (want == R_OK) ? 1 : 0);
        $display("txn enter: result=%b expected=%b latency=%0d", res, want, lat);
        cyc();
        chk("result_one_cycle", {bus.wrong_psw, bus.pin_ok}, R_NONE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.card_in     = 1'b0;
        bus.card_id     = 2'd0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.clear_key   = 1'b0;
        bus.enter_key   = 1'b0;
        bus.timeout     = 1'b0;
        bus.session_end = 1'b0;
        bus.pin_wr_en   = 1'b0;
        bus.pin_wr_acct = 2'd0;
        bus.pin_wr_data = 16'h0000;

        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        chk("reset_psw_en", bus.psw_en, 0);
        chk("reset_wrong_psw", bus.wrong_psw, 0);
        chk("reset_pin_ok", bus.pin_ok, 0);
        chk("reset_card_rejected", bus.card_rejected, 0);
        chk("reset_locked", bus.locked, 0);
        chk("reset_digit_count", bus.digit_count, 0);

        admin_write(2'd2, 16'h1234);
        admin_write(2'd1, 16'h5678);

        // Match on account 2, session held until session_end
        card(2'd2);
        key(4'd1);
        chk("count_after_1_digit", bus.digit_count, 1);
        key(4'd2); key(4'd3); key(4'd4);
        chk("count_after_4_digits", bus.digit_count, 4);
        submit(R_OK);
        chk("psw_en_held", bus.psw_en, 1);
        key(4'd5);
        chk("verified_ignores_keys", bus.digit_count, 0);
        chk("psw_en_still_held", bus.psw_en, 1);
        end_session();

        // Short entry, then overflow entry with an invalid BCD digit
        card(2'd2);
        key(4'd1); key(4'd2); key(4'd3);
        submit(R_WRONG);
        key(4'd1); key(4'd2);
        key(4'hA);
        chk("invalid_digit_ignored", bus.digit_count, 2);
        key(4'd3); key(4'd4); key(4'd9); key(4'd9);
        chk("overflow_count_saturates", bus.digit_count, 4);
        submit(R_OK);
        end_session();

        // Clear key discards partial entry
        card(2'd2);
        key(4'd1); key(4'd2);
        bus.clear_key = 1'b1;
        cyc();
        bus.clear_key = 1'b0;
        chk("clear_count", bus.digit_count, 0);
        key_pin(16'h1234);
        submit(R_OK);
        end_session();

        // Timeout mid-entry leaves the attempt counter untouched
        card(2'd2);
        key_pin(16'h9999);
        submit(R_WRONG);
        key(4'd1);
        bus.timeout = 1'b1;
        cyc();
        bus.timeout = 1'b0;
        chk("timeout_count", bus.digit_count, 0);
        key(4'd5);
        chk("timeout_back_in_idle", bus.digit_count, 0);
        card(2'd2);
        key_pin(16'h0000);
        submit(R_WRONG);
        chk("acct2_not_yet_locked", bus.locked, 4'b0000);
        key_pin(16'h0000);
        submit(R_WRONG);
        chk("acct2_locked_third_fail", bus.locked, 4'b0100);
        admin_write(2'd2, 16'h1234);
        chk("acct2_unlocked_by_write", bus.locked, 4'b0000);

        // Lockout on account 1
        card(2'd1);
        for (int i = 0; i < 3; i++) begin
            key_pin(16'h0000);
            submit(R_WRONG);
        end
        chk("acct1_locked", bus.locked, 4'b0010);
        key(4'd3);
        chk("idle_after_lock", bus.digit_count, 0);
        card(2'd1);
        chk("card_rejected_pulse", bus.card_rejected, 1);
        chk("rejected_psw_en", bus.psw_en, 0);
        cyc();
        chk("card_rejected_one_cycle", bus.card_rejected, 0);

        // Admin unlock with a new PIN
        admin_write(2'd1, 16'h4321);
        chk("acct1_unlocked", bus.locked, 4'b0000);
        card(2'd1);
        key_pin(16'h4321);
        submit(R_OK);
        end_session();

        // Reset mid-entry wipes outputs and stored PINs
        card(2'd1);
        key(4'd4); key(4'd3);
        chk("count_before_reset", bus.digit_count, 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_psw_en", bus.psw_en, 0);
        chk("rst_wrong_psw", bus.wrong_psw, 0);
        chk("rst_pin_ok", bus.pin_ok, 0);
        chk("rst_card_rejected", bus.card_rejected, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_digit_count", bus.digit_count, 0);
        card(2'd1);
        key_pin(16'h0000);
        submit(R_OK);
        end_session();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
